// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: direct and indirect (LDI/STI) loads/stores,
// byte lane steering, pipeline stall generation and a saturating stall-cycle counter.
module mem_access_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 op_read,
  input  logic                 op_write,
  input  logic                 op_byte,
  input  logic                 op_indirect,
  input  logic [15:0]          addr,
  input  logic [15:0]          wdata,
  output logic                 dmem_read,
  output logic                 dmem_write,
  output logic [15:0]          dmem_address,
  output logic [15:0]          dmem_wdata,
  output logic [1:0]           dmem_byte_enable,
  input  logic                 dmem_resp,
  input  logic [15:0]          dmem_rdata,
  output logic                 stall,
  output logic [15:0]          mdr_out,
  output logic                 mar_lsb_out,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE, IND, ACCESS} stateT;

  stateT                r_state;
  logic [15:0]          r_ptr;
  logic [15:0]          r_mdr;
  logic [CNT_WIDTH-1:0] r_stallCnt;

  logic        w_memOp;
  logic        w_isRead;
  logic        w_isWrite;
  logic        w_inInd;
  logic        w_inAccess;
  logic        w_finalResp;
  logic [15:0] w_eff;

  // A request with both op bits set is serviced as a read.
  assign w_memOp     = req_valid & (op_read | op_write);
  assign w_isRead    = op_read;
  assign w_isWrite   = op_write & ~op_read;
  assign w_inInd     = (r_state == IND);
  assign w_inAccess  = (r_state == ACCESS);
  assign w_finalResp = w_inAccess & dmem_resp;
  assign w_eff       = op_indirect ? r_ptr : addr;

  assign dmem_read        = w_inInd | (w_inAccess & w_isRead);
  assign dmem_write       = w_inAccess & w_isWrite;
  assign dmem_address     = w_inAccess ? w_eff : addr;
  assign dmem_byte_enable = (w_inAccess & op_byte) ? (w_eff[0] ? 2'b10 : 2'b01) : 2'b11;
  assign dmem_wdata       = op_byte ? {wdata[7:0], wdata[7:0]} : wdata;

  assign stall       = w_memOp & ~w_finalResp;
  assign mdr_out     = w_finalResp ? dmem_rdata : r_mdr;
  assign mar_lsb_out = w_inAccess & w_eff[0];
  assign stall_cnt   = r_stallCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 16'h0000;
      r_mdr   <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memOp) r_state <= op_indirect ? IND : ACCESS;
        end
        IND: begin
          if (dmem_resp) begin
            r_ptr   <= dmem_rdata;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            if (w_isRead) r_mdr <= dmem_rdata;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturates at all-ones so long stalls never wrap back to small counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (stall && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + CNT_WIDTH'(1);
    end
  end

endmodule
